csa_seq_add_ctrl: RTL
=====================

# csa_seq_add_ctrl

Multi-cycle sequencer that time-shares one narrow carry-select adder slice across a wide addition. An accepted start captures the operands. The controller then feeds one SLICE-bit chunk per clock through the slice, least significant chunk first, and chains the carry through a register. It ends with a one-cycle done pulse. It sits between the switch/register front end and the hex-display/result registers, and replaces a full-width combinational adder when area matters more than latency.

## Interface
- WIDTH, 16, total operand/result width; must be a positive multiple of SLICE
- SLICE, 4, width of the shared carry-select slice; N = WIDTH/SLICE chunks per addition
- Clk  input  1  sole clock; all state updates on rising edge
- Reset_n  input  1  asynchronous, active-low reset; clears all state immediately
- start  input  1  request a new addition; sampled on rising edge of Clk
- a  input  WIDTH  operand A, captured only when start is accepted
- b  input  WIDTH  operand B, captured only when start is accepted
- c_in  input  1  carry into chunk 0, captured with the operands
- busy  output  1  high while an addition is in progress (RUN)
- done  output  1  one-cycle pulse: sum/c_out valid and newly updated
- sum  output  WIDTH  result register; holds until the next accepted start
- c_out  output  1  carry out of the top chunk; holds with sum
- ovf  output  1  signed overflow of the completed result (only with CSA_SEQ_OVF_EN)

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: busy=0, done=0, sum=0, c_out=0, ovf=0, chunk counter=0, carry register=0.
- IDLE or DONE with start=1: capture a, b into operand shift registers and c_in into the carry register. Clear the counter, clear sum, go to RUN.
- DONE with start=0: go to IDLE.
- RUN, chunk k (k = counter):
  - drive slice with a[k*SLICE +: SLICE], b[k*SLICE +: SLICE] and the carry register
  - write slice sum into sum[k*SLICE +: SLICE]
  - load the carry register with the slice carry-out
  - increment the counter
- RUN at k = N-1: also write c_out from the final slice carry, go to DONE.
- start while in RUN is ignored. There is no queueing and captured operands are not disturbed.
- Changes on a, b and c_in after capture have no effect on the running addition.
- Counter width is clog2(N), with a minimum of 1 bit. The counter never wraps during RUN because the exit occurs at N-1.
- WIDTH == SLICE (N=1): RUN lasts exactly one cycle.
- Arithmetic is unsigned modulo 2^WIDTH with carry. {c_out, sum} equals a + b + c_in exactly.

## Timing
- Start accepted at rising edge E0 → busy=1 from E0 until edge EN.
- Chunk k is written at edge E(k+1).
- done=1 for exactly the cycle following edge EN. busy=0 in that cycle.
- Latency: N cycles from the start edge to done. Throughput: one addition per N+1 cycles. Back-to-back is allowed by asserting start during DONE.
- Reset_n low at any time, including mid-RUN: outputs go to reset values asynchronously and the partial result is discarded. Operation resumes from IDLE on the first edge after Reset_n deasserts.
- Simultaneous start and Reset_n low: reset wins.

## Configuration
- CSA_SEQ_OVF_EN defined: ovf port exists. At the edge that writes the top chunk, ovf is set to (carry into MSB) XOR (carry out of MSB). ovf holds with sum and clears on an accepted start and on reset.
- CSA_SEQ_OVF_EN undefined: no ovf port and no MSB-carry tap logic.

## Structure
- Shared package csa_pkg holds:
  - the state enum typedef (IDLE, RUN, DONE)
  - default WIDTH/SLICE constants
  - a localparam function computing N and the counter width
- One sub-module, csa_slice: a purely combinational SLICE-bit carry-select adder built from duplicated ripple halves for carry 0/1 plus a mux. Instantiated exactly once.
- The controller owns the FSM, the counter, the operand registers, the carry register and the result registers.

## Test plan
- a=0x1234, b=0x4321, c_in=0, start one cycle → busy for 4 cycles, done pulse at 4 cycles after the start edge, sum=0x5555, c_out=0.
- a=0xFFFF, b=0x0001, c_in=0 → carry ripples through all 4 chunks; sum=0x0000, c_out=1.
- a=0xFFFF, b=0x0000, c_in=1 → sum=0x0000, c_out=1. Repeat with c_in=0 → sum=0xFFFF, c_out=0.
- Start 0x0001+0x0001. Pulse start again with 0x00FF+0x0001 during RUN → second request ignored; result sum=0x0002. Then start during DONE with 0x00FF+0x0001 → sum=0x0100 after 4 more cycles.
- Reset_n low in the cycle after chunk 1 is written → sum=0, busy=0, done=0 immediately. The next start of 0x0F0F+0xF0F0 gives sum=0xFFFF, c_out=0.
- With CSA_SEQ_OVF_EN: 0x7FFF+0x0001 → sum=0x8000, ovf=1. 0xFFFF+0x0001 → ovf=0, c_out=1.

Source files
------------

// File: rtl/csa_pkg.sv
// Shared types and sizing helpers for the sequential carry-select adder.
package csa_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SLICE = 4;

  function automatic int calc_n(input int width, input int slice);
    return width / slice;
  endfunction

  // The counter needs at least one bit, even when a single chunk makes up the whole operand.
  function automatic int calc_cnt_w(input int width, input int slice);
    int n;
    n = width / slice;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/csa_slice.sv
// Combinational SLICE-bit carry-select adder: low half ripples, high half is
// computed for both carry values and selected by the low-half carry.
module csa_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             ci,
  output logic [SLICE-1:0] s,
  output logic             co
);

  if (SLICE == 1) begin : g_single
    assign {co, s} = {1'b0, a} + {1'b0, b} + 2'(ci);
  end else begin : g_split
    localparam int LO = SLICE / 2;
    localparam int HI = SLICE - LO;

    logic [LO:0] lo_r;
    logic [HI:0] hi0, hi1;

    assign lo_r = {1'b0, a[LO-1:0]} + {1'b0, b[LO-1:0]} + (LO+1)'(ci);
    assign hi0  = {1'b0, a[SLICE-1:LO]} + {1'b0, b[SLICE-1:LO]};
    assign hi1  = {1'b0, a[SLICE-1:LO]} + {1'b0, b[SLICE-1:LO]} + (HI+1)'(1);

    assign s[LO-1:0]          = lo_r[LO-1:0];
    assign {co, s[SLICE-1:LO]} = lo_r[LO] ? hi1 : hi0;
  end

endmodule

// File: rtl/csa_seq_add_ctrl.sv
// Sequencer that pushes a WIDTH-bit add through one shared SLICE-bit adder,
// LSB chunk first. Optional signed-overflow output under CSA_SEQ_OVF_EN.
module csa_seq_add_ctrl
  import csa_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef CSA_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N     = calc_n(WIDTH, SLICE);
  localparam int CNT_W = calc_cnt_w(WIDTH, SLICE);

  state_t             state_q, state_d;
  logic               load, step, last;
  logic [WIDTH-1:0]   a_q, b_q, sum_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               cy_q, c_out_q;
  logic [SLICE-1:0]   slice_s;
  logic               slice_co;

  csa_slice #(.SLICE(SLICE)) u_slice (
    .a  (a_q[SLICE-1:0]),
    .b  (b_q[SLICE-1:0]),
    .ci (cy_q),
    .s  (slice_s),
    .co (slice_co)
  );

  assign last = (cnt_q == CNT_W'(N - 1));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        load    = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        step = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operands shift down so the slice always sees the current chunk in the low bits.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      a_q     <= '0;
      b_q     <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else if (load) begin
      a_q   <= a;
      b_q   <= b;
      cy_q  <= c_in;
      cnt_q <= '0;
      sum_q <= '0;
    end else if (step) begin
      a_q                              <= a_q >> SLICE;
      b_q                              <= b_q >> SLICE;
      sum_q[int'(cnt_q)*SLICE +: SLICE] <= slice_s;
      cy_q                             <= slice_co;
      cnt_q                            <= last ? '0 : cnt_q + CNT_W'(1);
      if (last) c_out_q <= slice_co;
    end
  end

`ifdef CSA_SEQ_OVF_EN
  // Carry into the MSB recovered from its sum bit: s = a ^ b ^ cin.
  logic c_msb, ovf_q;
  assign c_msb = a_q[SLICE-1] ^ b_q[SLICE-1] ^ slice_s[SLICE-1];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)          ovf_q <= 1'b0;
    else if (load)         ovf_q <= 1'b0;
    else if (step && last) ovf_q <= c_msb ^ slice_co;
  end

  assign ovf = ovf_q;
`endif

  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign c_out = c_out_q;

endmodule
